sram_lane_pack_writer: RTL and testbench

//  Write-side initiator for the 4096x32 single-port weight/activation SRAM, which the MAC engine reads back as four 8-bit lanes.

---
 rtl/sram_wr_pkg.sv | 22 ++
 rtl/sram_lane_packer.sv | 41 ++++
 rtl/sram_lane_pack_writer.sv | 138 +++++++++++++
 tb/tb_sram_lane_pack_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wr_pkg.sv
// Shared constants, FSM states and lane-to-bit mapping for the SRAM lane-pack writer.
package sram_wr_pkg;

    localparam int ADDR_W = 12;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } state_e;

    // LSB of the D bit range for lane k; lane 0 sits in the top byte.
    function automatic int lane_slice(input int k);
        return DATA_W - LANE_W * (k + 1);
    endfunction

endpackage

// File: rtl/sram_lane_packer.sv
// Collects accepted bytes into lanes 0..LANES-1 and presents a complete (or last, zero-padded) word.
module sram_lane_packer
    import sram_wr_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [LANE_W-1:0] byte_i,
    input  logic              last_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [LANE_W-1:0] lane_q [LANES];

    assign word_valid_o = accept_i & (last_i | (cnt_q == CNT_W'(LANES - 1)));

    // Lanes above the current byte are forced to zero, so stale lane_q contents never leak.
    always_comb begin
        word_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(cnt_q)) begin
                word_o[lane_slice(k) +: LANE_W] = lane_q[k];
            end else if (k == int'(cnt_q)) begin
                word_o[lane_slice(k) +: LANE_W] = byte_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (accept_i) begin
            lane_q[cnt_q] <= byte_i;
            cnt_q         <= word_valid_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_lane_pack_writer.sv
// Packs a valid/ready byte stream into 32-bit words and writes them to the SRAM at incrementing addresses.
module sram_lane_pack_writer
    import sram_wr_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   num_words_i,
    input  logic              in_valid_i,
    input  logic [LANE_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              CEB_o,
    output logic              WEB_o,
    output logic [ADDR_W-1:0] A_o,
    output logic [DATA_W-1:0] D_o,
    output logic              busy_o,
    output logic              done_o
);

    // Handshake: a byte transfers on a rising edge where in_valid_i and in_ready_o are both 1;
    // in_ready_o is registered and never depends on in_valid_i.

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              ready_d, busy_d, done_d, ceb_d, web_d;
    logic [ADDR_W-1:0] a_d;
    logic [DATA_W-1:0] d_d;

    logic              accept;
    logic              clear;
    logic              word_valid;
    logic [DATA_W-1:0] word;
    logic              final_word;

    assign accept     = in_valid_i & in_ready_o;
    assign clear      = (state_q == IDLE) & start_i;
    assign final_word = word_valid & (in_last_i | ((wcnt_q + (ADDR_W + 1)'(1)) == num_q));

    sram_lane_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear),
        .accept_i     (accept),
        .byte_i       (in_data_i),
        .last_i       (in_last_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        wcnt_d  = wcnt_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ceb_d   = 1'b1;
        web_d   = 1'b1;
        a_d     = A_o;
        d_d     = D_o;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    num_d  = num_words_i;
                    wcnt_d = '0;
                    if (num_words_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                busy_d  = 1'b1;
                ready_d = 1'b1;
                if (word_valid) begin
                    ceb_d  = 1'b0;
                    web_d  = 1'b0;
                    a_d    = addr_q;
                    d_d    = word;
                    addr_d = addr_q + ADDR_W'(1);
                    wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
                end
                if (final_word) begin
                    ready_d = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The final write strobe is on the bus during this state.
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            num_q      <= '0;
            wcnt_q     <= '0;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            CEB_o      <= 1'b1;
            WEB_o      <= 1'b1;
            A_o        <= '0;
            D_o        <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            num_q      <= num_d;
            wcnt_q     <= wcnt_d;
            in_ready_o <= ready_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            CEB_o      <= ceb_d;
            WEB_o      <= web_d;
            A_o        <= a_d;
            D_o        <= d_d;
        end
    end

endmodule

// File: tb/tb_sram_lane_pack_writer.sv
// Directed and randomized transfers checked against a byte-to-word packing model of the SRAM writes.
module tb_sram_lane_pack_writer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [11:0] base_addr_i = '0;
    logic [12:0] num_words_i = '0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = '0;
    logic        in_last_i = 1'b0;
    logic        in_ready_o, CEB_o, WEB_o, busy_o, done_o;
    logic [11:0] A_o;
    logic [31:0] D_o;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cyc = 0;
    logic [11:0] obs_a_q[$];
    logic [31:0] obs_d_q[$];
    int          last_wr_cyc, done_cyc, start_cyc, done_cnt, strobe_bad;
    logic        done_busy, ready_seen;

    // Expected writes
    logic [11:0] exp_a_q[$];
    logic [31:0] exp_d_q[$];

    sram_lane_pack_writer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_words_i (num_words_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .CEB_o       (CEB_o),
        .WEB_o       (WEB_o),
        .A_o         (A_o),
        .D_o         (D_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!CEB_o) begin
            obs_a_q.push_back(A_o);
            obs_d_q.push_back(D_o);
            last_wr_cyc = cyc;
        end
        if (CEB_o !== WEB_o) strobe_bad = strobe_bad + 1;
        if (done_o) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy_o;
        end
        if (in_ready_o) ready_seen = 1'b1;
        if (start_i) start_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_monitor();
        obs_a_q.delete();
        obs_d_q.delete();
        last_wr_cyc = -100;
        done_cyc    = -100;
        start_cyc   = -100;
        done_cnt    = 0;
        strobe_bad  = 0;
        done_busy   = 1'b1;
        ready_seen  = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] base, input logic [12:0] num);
        @(posedge clk); #1;
        clear_monitor();
        start_i     = 1'b1;
        base_addr_i = base;
        num_words_i = num;
        @(posedge clk); #1;
        start_i     = 1'b0;
        base_addr_i = 12'($urandom);
        num_words_i = 13'($urandom);
    endtask

    // Offers one byte for a bounded number of cycles; got=1 if it was consumed.
    task automatic drive_byte(input logic [7:0] b, input bit last, input int max_gap, output bit got);
        repeat ($urandom_range(0, max_gap)) begin
            in_data_i = 8'($urandom);
            in_last_i = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b1;
        in_data_i  = b;
        in_last_i  = last;
        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            @(negedge clk);
            if (in_ready_o) got = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'($urandom);
    endtask

    task automatic run_xfer(input string name, input logic [11:0] base, input logic [12:0] num,
                            input int nbytes, input int last_idx, input int max_gap, input bit rnd_data);
        logic [7:0]  b[$];
        logic [31:0] w;
        logic [11:0] a;
        int          k, exp_acc, acc, nexp;
        bit          got;
        for (int i = 0; i < nbytes; i++)
            b.push_back(rnd_data ? 8'($urandom) : 8'(8'h11 * (i + 1)));

        // Model: byte k of each word lands at bits [31-8k -: 8]; a word closes on 4 bytes or last.
        exp_a_q.delete();
        exp_d_q.delete();
        exp_acc = 0; a = base; w = '0; k = 0;
        if (num != 0) begin
            for (int i = 0; i < nbytes; i++) begin
                w = w | (32'(b[i]) << (8 * (3 - k)));
                k++;
                exp_acc++;
                if (k == 4 || i == last_idx) begin
                    exp_a_q.push_back(a);
                    exp_d_q.push_back(w);
                    a = 12'((int'(a) + 1) % 4096);
                    w = '0; k = 0;
                    if (exp_d_q.size() == int'(num) || i == last_idx) break;
                end
            end
        end
        nexp = exp_d_q.size();

        do_start(base, num);
        acc = 0;
        for (int i = 0; i < nbytes; i++) begin
            drive_byte(b[i], i == last_idx, max_gap, got);
            if (!got) break;
            acc++;
        end
        for (int t = 0; t < 60 && done_cnt == 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);

        chk({name, " accepted_bytes"}, 64'(acc), 64'(exp_acc));
        chk({name, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, " write_count"}, 64'(obs_d_q.size()), 64'(nexp));
        while (exp_d_q.size() > 0 && obs_d_q.size() > 0) begin
            chk({name, " write_addr"}, 64'(obs_a_q.pop_front()), 64'(exp_a_q.pop_front()));
            chk({name, " write_data"}, 64'(obs_d_q.pop_front()), 64'(exp_d_q.pop_front()));
        end
        if (num == 0) begin
            chk({name, " done_after_start"}, 64'(done_cyc), 64'(start_cyc + 1));
            chk({name, " ready_never_rose"}, 64'(ready_seen), 64'd0);
        end else begin
            chk({name, " done_after_write"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
        end
        chk({name, " busy_in_done"}, 64'(done_busy), 64'd0);
        chk({name, " ceb_web_paired"}, 64'(strobe_bad), 64'd0);
        chk({name, " idle_after"}, {62'd0, busy_o, in_ready_o}, 64'd0);
    endtask

    initial begin
        bit got;
        clear_monitor();

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {in_ready_o, busy_o, done_o, CEB_o, WEB_o, A_o, D_o},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 32'h0});

        // Back-to-back 2 words, one extra byte offered that must be refused
        run_xfer("c1_basic", 12'h010, 13'd2, 9, -1, 0, 1'b0);
        // Early last on the 6th byte of a 4-word transfer
        run_xfer("c2_early_last", 12'h040, 13'd4, 8, 5, 0, 1'b0);
        // Address wrap
        run_xfer("c3_wrap", 12'hFFF, 13'd2, 8, -1, 0, 1'b0);
        // Random gaps over 3 words
        run_xfer("c4_gaps", 12'($urandom), 13'd3, 12, -1, 3, 1'b1);
        // Last exactly on the 4th byte: single write, no zero word
        run_xfer("c4b_last_on_4th", 12'h200, 13'd3, 8, 3, 1, 1'b1);

        // Reset in the middle of word 0
        do_start(12'h100, 13'd3);
        drive_byte(8'hA1, 1'b0, 0, got);
        drive_byte(8'hA2, 1'b0, 0, got);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("c5_reset_outputs", {CEB_o, busy_o, in_ready_o, done_o}, {1'b1, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("c5_no_write", 64'(obs_d_q.size()), 64'd0);
        run_xfer("c5_fresh", 12'h120, 13'd1, 4, -1, 0, 1'b1);

        // Zero-length transfer
        run_xfer("c6_zero", 12'h300, 13'd0, 3, -1, 0, 1'b1);

        // Randomized transfers
        for (int r = 0; r < 4; r++) begin
            int n, nb, li;
            n  = $urandom_range(1, 4);
            nb = n * 4 + 2;
            li = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
            run_xfer("rnd", 12'($urandom), 13'(n), nb, li, 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
